alu_op_decoder: RTL and testbench

Decode-and-issue stage that sits upstream of the single-cycle datapath ALU and produces its operands and 4-bit operation code. It accepts one instruction word plus register-file read data per valid/ready handshake. It decodes the RV32I OP, OP-IMM and LUI classes into `src_a`, `src_b` and `alu_ctrl`, and delivers the result through a 2-entry skid buffer so both handshake directions are fully registered.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_op_decoder_if.sv | 47 ++++
 rtl/alu_dec_core.sv | 94 +++++++++
 rtl/alu_op_decoder.sv | 134 +++++++++++++
 tb/tb_alu_op_decoder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath and the decode/issue stage in front
// of it. This file holds the 4-bit ALU operation codes, the RV32I opcode
// constants for the classes this stage decodes, the funct7 constants, and a
// funct3-to-operation helper that is shared by the OP and OP-IMM classes.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_NOP  = 4'b1111   // ALU returns 0
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 to ALU code. 'alt' selects SUB over ADD and SRA over SRL; the
    // caller decides whether the alternate encoding applies to its class.
    function automatic alu_ctrl_e f3_to_ctrl(input logic [2:0] f3, input logic alt);
        unique case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage : alu_pkg

// File: rtl/alu_op_decoder_if.sv
// -----------------------------------------------------------------------------
// alu_op_decoder_if
// Handshake and payload bundle for the decode/issue stage.
//   Upstream side  : in_valid, in_ready, instr, rs1_data, rs2_data
//   Downstream side: out_valid, out_ready, src_a, src_b, alu_ctrl, rd
//                    illegal (only when ALU_DEC_ILLEGAL_EN is defined)
// modport slave  : the decoder itself
// modport master : the environment (instruction source plus ALU sink)
// -----------------------------------------------------------------------------
interface alu_op_decoder_if
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    alu_ctrl_e         alu_ctrl;
    logic [4:0]        rd;
`ifdef ALU_DEC_ILLEGAL_EN
    logic              illegal;
`endif

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, src_a, src_b, alu_ctrl, rd
`ifdef ALU_DEC_ILLEGAL_EN
        , output illegal
`endif
    );

    modport master (
        output in_valid, instr, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, src_a, src_b, alu_ctrl, rd
`ifdef ALU_DEC_ILLEGAL_EN
        , input illegal
`endif
    );

endinterface : alu_op_decoder_if

// File: rtl/alu_dec_core.sv
// -----------------------------------------------------------------------------
// alu_dec_core
// Purely combinational RV32I decode of the OP, OP-IMM and LUI classes into ALU
// operands and operation code.
//   instr       : instruction word
//   rs1_data    : register-file read port 1
//   rs2_data    : register-file read port 2
//   src_a/src_b : ALU operands (both 0 for unsupported instructions)
//   alu_ctrl    : ALU operation (NOP for unsupported instructions)
//   rd          : destination register, instr[11:7]
//   unsupported : instruction is outside the decoded subset
// -----------------------------------------------------------------------------
module alu_dec_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 32   // only 32 is supported
) (
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] src_a,
    output logic [DATA_W-1:0] src_b,
    output alu_ctrl_e         alu_ctrl,
    output logic [4:0]        rd,
    output logic              unsupported
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rd     = instr[11:7];

    // NOTE: every output gets a default before the case statement so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        legal    = 1'b0;
        src_a    = '0;
        src_b    = '0;
        alu_ctrl = ALU_NOP;

        unique case (opcode)
            OPC_OP: begin
                legal    = (f7 == F7_BASE) ||
                           ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
                alu_ctrl = f3_to_ctrl(f3, f7[5]);
                src_a    = rs1_data;
                src_b    = rs2_data;
            end

            OPC_OP_IMM: begin
                src_a = rs1_data;
                unique case (f3)
                    3'b001: begin
                        legal = (f7 == F7_BASE);
                        src_b = {{(DATA_W-5){1'b0}}, instr[24:20]};
                    end
                    3'b101: begin
                        legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                        src_b = {{(DATA_W-5){1'b0}}, instr[24:20]};
                    end
                    default: begin
                        legal = 1'b1;
                        src_b = {{(DATA_W-12){instr[31]}}, instr[31:20]};
                    end
                endcase
                // ADDI has no SUB form: only the right shift honours funct7.
                alu_ctrl = f3_to_ctrl(f3, (f3 == 3'b101) && f7[5]);
            end

            OPC_LUI: begin
                legal    = 1'b1;
                src_b    = DATA_W'({instr[31:12], 12'b0});
                alu_ctrl = ALU_ADD;
            end

            default: legal = 1'b0;
        endcase

        // Unsupported instructions carry a clean NOP payload.
        if (!legal) begin
            src_a    = '0;
            src_b    = '0;
            alu_ctrl = ALU_NOP;
        end
    end

    assign unsupported = !legal;

endmodule : alu_dec_core

// File: rtl/alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
// Decode-and-issue stage in front of the single-cycle ALU. Decodes one
// instruction per valid/ready handshake and delivers the result through a
// 2-entry skid buffer (main + skid register) so both in_ready and the output
// payload come straight from flops.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; discards both entries at once
//   bus   : alu_op_decoder_if.slave (upstream and downstream handshakes)
// Build option ALU_DEC_ILLEGAL_EN:
//   defined   - unsupported instructions are forwarded as NOP entries with
//               illegal=1
//   undefined - unsupported instructions complete the input handshake but are
//               dropped before the buffer; no illegal port exists
// -----------------------------------------------------------------------------
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int DATA_W = 32   // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_op_decoder_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0] src_a;
        logic [DATA_W-1:0] src_b;
        alu_ctrl_e         alu_ctrl;
        logic [4:0]        rd;
`ifdef ALU_DEC_ILLEGAL_EN
        logic              illegal;
`endif
    } entry_t;

    localparam entry_t ENTRY_RST = '{alu_ctrl: ALU_NOP, default: '0};

    entry_t dec_entry;
    logic   dec_unsupported;

    entry_t main_q, main_n;
    entry_t skid_q, skid_n;
    logic   main_valid_q, main_valid_n;
    logic   skid_valid_q, skid_valid_n;
    logic   in_ready_q;

    logic   accept;
    logic   push;
    logic   drain;

    alu_dec_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .instr       (bus.instr),
        .rs1_data    (bus.rs1_data),
        .rs2_data    (bus.rs2_data),
        .src_a       (dec_entry.src_a),
        .src_b       (dec_entry.src_b),
        .alu_ctrl    (dec_entry.alu_ctrl),
        .rd          (dec_entry.rd),
        .unsupported (dec_unsupported)
    );

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = main_valid_q && bus.out_ready;

`ifdef ALU_DEC_ILLEGAL_EN
    assign dec_entry.illegal = dec_unsupported;
    assign push              = accept;
`else
    // Handshake still completes for unsupported instructions; they simply
    // never occupy a buffer slot.
    assign push              = accept && !dec_unsupported;
`endif

    // Occupancy update. A push never coincides with a full skid slot because
    // in_ready is low then, so after a drain the next entry always has room.
    always_comb begin
        main_n       = main_q;
        skid_n       = skid_q;
        main_valid_n = main_valid_q;
        skid_valid_n = skid_valid_q;

        if (drain) begin
            if (skid_valid_q) begin
                main_n       = skid_q;
                skid_valid_n = 1'b0;
            end else begin
                main_valid_n = 1'b0;
            end
        end

        if (push) begin
            if (!main_valid_n) begin
                main_n       = dec_entry;
                main_valid_n = 1'b1;
            end else begin
                skid_n       = dec_entry;
                skid_valid_n = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    // NOTE: payload registers are reset too, since the outputs must read as a
    // defined NOP during and straight after reset, not just out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= ENTRY_RST;
            skid_q       <= ENTRY_RST;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_n;
            skid_q       <= skid_n;
            main_valid_q <= main_valid_n;
            skid_valid_q <= skid_valid_n;
            in_ready_q   <= !skid_valid_n;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid_q;
    assign bus.src_a     = main_q.src_a;
    assign bus.src_b     = main_q.src_b;
    assign bus.alu_ctrl  = main_q.alu_ctrl;
    assign bus.rd        = main_q.rd;
`ifdef ALU_DEC_ILLEGAL_EN
    assign bus.illegal   = main_q.illegal;
`endif

endmodule : alu_op_decoder

// File: tb/tb_alu_op_decoder.sv
// -----------------------------------------------------------------------------
// tb_alu_op_decoder
// Directed self-checking bench for alu_op_decoder. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point, well away from
// the next edge. Expected values are hand-computed from the instruction
// encodings.
// -----------------------------------------------------------------------------
module tb_alu_op_decoder;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_op_decoder_if #(.DATA_W(32)) bus ();

    alu_op_decoder #(
        .DATA_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.instr    = i;
        bus.rs1_data = a;
        bus.rs2_data = b;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.instr    = 32'h0000_0013;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
    endtask

    // addi xk, x0, k  -> src_b = k, rd = k
    function automatic logic [31:0] addi_k(input int k);
        return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        tick();
        tick();

        // Reset state
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("rst_src_a",     bus.src_a,              32'h0);
        check("rst_src_b",     bus.src_b,              32'h0);
        check("rst_alu_ctrl",  32'(bus.alu_ctrl),      32'hF);
        check("rst_rd",        32'(bus.rd),            32'h0);
`ifdef ALU_DEC_ILLEGAL_EN
        check("rst_illegal",   {31'b0, bus.illegal},   32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // sub x0,x1,x2 : 1-cycle latency
        present(32'h4020_8033, 32'd5, 32'd3);
        tick();
        idle();
        check("sub_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("sub_alu_ctrl",  32'(bus.alu_ctrl),      32'h1);
        check("sub_src_a",     bus.src_a,              32'd5);
        check("sub_src_b",     bus.src_b,              32'd3);
        check("sub_rd",        32'(bus.rd),            32'd0);
`ifdef ALU_DEC_ILLEGAL_EN
        check("sub_illegal",   {31'b0, bus.illegal},   32'd0);
`endif
        tick();
        check("sub_drained",   {31'b0, bus.out_valid}, 32'd0);

        // srai x1,x1,4 followed back-to-back by addi x1,x0,-1
        present(32'h4040_D093, 32'h8000_0000, 32'h0);
        tick();
        present(32'hFFF0_0093, 32'h0, 32'h0);
        check("srai_alu_ctrl", 32'(bus.alu_ctrl),      32'h7);
        check("srai_src_a",    bus.src_a,              32'h8000_0000);
        check("srai_src_b",    bus.src_b,              32'd4);
        check("srai_rd",       32'(bus.rd),            32'd1);
        tick();
        // accept and drain together: occupancy stays 1, in_ready stays 1
        present(32'h1234_50B7, 32'hDEAD_BEEF, 32'h0);
        check("addi_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("addi_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("addi_alu_ctrl",  32'(bus.alu_ctrl),      32'h0);
        check("addi_src_b",     bus.src_b,              32'hFFFF_FFFF);
        tick();
        // or x3,x1,x2
        present(32'h0020_E1B3, 32'h0000_00F0, 32'h0000_000F);
        check("lui_src_a",     bus.src_a,              32'h0);
        check("lui_src_b",     bus.src_b,              32'h1234_5000);
        check("lui_rd",        32'(bus.rd),            32'd1);
        check("lui_alu_ctrl",  32'(bus.alu_ctrl),      32'h0);
        tick();
        idle();
        check("or_alu_ctrl",   32'(bus.alu_ctrl),      32'h3);
        check("or_src_a",      bus.src_a,              32'h0000_00F0);
        check("or_src_b",      bus.src_b,              32'h0000_000F);
        check("or_rd",         32'(bus.rd),            32'd3);
        tick();
        check("or_drained",    {31'b0, bus.out_valid}, 32'd0);

        // Backpressure: out_ready low for 5 edges, 4 instructions offered
        bus.out_ready = 1'b0;
        present(addi_k(1), 32'h0, 32'h0);
        tick();                                               // edge 1: I1 -> main
        present(addi_k(2), 32'h0, 32'h0);
        check("bp1_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("bp1_src_b",    bus.src_b,             32'd1);
        tick();                                               // edge 2: I2 -> skid
        present(addi_k(3), 32'h0, 32'h0);
        check("bp2_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("bp2_src_b",    bus.src_b,             32'd1);
        tick();                                               // edge 3: stalled
        check("bp3_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("bp3_stable_b", bus.src_b,             32'd1);
        check("bp3_stable_rd", 32'(bus.rd),          32'd1);
        tick();                                               // edge 4
        check("bp4_stable_b", bus.src_b,             32'd1);
        tick();                                               // edge 5
        check("bp5_stable_b", bus.src_b,             32'd1);
        check("bp5_out_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        tick();                                               // edge 6: I1 out, I2 -> main
        check("bp6_src_b",    bus.src_b,             32'd2);
        check("bp6_rd",       32'(bus.rd),           32'd2);
        check("bp6_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();                                               // edge 7: I2 out, I3 in
        present(addi_k(4), 32'h0, 32'h0);
        check("bp7_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("bp7_src_b",    bus.src_b,             32'd3);
        tick();                                               // edge 8: I3 out, I4 in
        idle();
        check("bp8_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("bp8_src_b",    bus.src_b,             32'd4);
        tick();                                               // edge 9: I4 out
        check("bp9_drained",  {31'b0, bus.out_valid}, 32'd0);

        // Unsupported opcode (load)
        present(32'h0000_0003, 32'h1111_1111, 32'h2222_2222);
        tick();
        idle();
        check("ld_in_ready",  {31'b0, bus.in_ready},  32'd1);
`ifdef ALU_DEC_ILLEGAL_EN
        check("ld_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("ld_illegal",   {31'b0, bus.illegal},   32'd1);
        check("ld_alu_ctrl",  32'(bus.alu_ctrl),      32'hF);
        check("ld_src_a",     bus.src_a,              32'h0);
        check("ld_src_b",     bus.src_b,              32'h0);
`else
        check("ld_out_valid", {31'b0, bus.out_valid}, 32'd0);
`endif
        tick();

        // Unsupported OP encoding: funct7=0100000 with funct3=110
        present(32'h4020_E1B3, 32'h5, 32'h6);
        tick();
        idle();
`ifdef ALU_DEC_ILLEGAL_EN
        check("bad_op_illegal",   {31'b0, bus.illegal},   32'd1);
        check("bad_op_alu_ctrl",  32'(bus.alu_ctrl),      32'hF);
`else
        check("bad_op_out_valid", {31'b0, bus.out_valid}, 32'd0);
`endif
        tick();

        // Reset asserted with both entries occupied
        bus.out_ready = 1'b0;
        present(addi_k(5), 32'h0, 32'h0);
        tick();
        present(addi_k(6), 32'h0, 32'h0);
        tick();
        idle();
        check("mid_full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("mid_rst_src_b",     bus.src_b,              32'h0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("mid_post_out_valid", {31'b0, bus.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_op_decoder
